bt_free_arbiter: RTL
====================

# bt_free_arbiter

Shares the busy table's two free (writeback-ready) ports among up to NUM_REQ writeback requesters: integer ALU, mul/div, LSU, CSR. Each requester hands off one physical destination register (prd) per cycle through a valid/ready handshake into a one-entry pending slot. A round-robin scheduler drains at most two pending slots per cycle onto free port 0 and free port 1. During the ROB overwrite-RAT state all pending work is discarded, because the busy table clears itself then.

## Interface
Parameters
- NUM_REQ, 4, number of writeback requesters (2..8)
- PREG_W, 6, physical register index width
- CNT_W, 16, width of the conflict performance counter

Ports
- clock  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  requester i presents a prd
- req_prd  in  NUM_REQ*PREG_W  prd of requester i, packed at [i*PREG_W +: PREG_W]
- req_ready  out  NUM_REQ  requester i may hand off this cycle
- free0_en  out  1  busy-table free port 0 enable
- free0_rd  out  PREG_W  busy-table free port 0 prd
- free1_en  out  1  busy-table free port 1 enable
- free1_rd  out  PREG_W  busy-table free port 1 prd
- rob_state  in  2  ROB state; `ROB_STATE_OVERWRITE_RAT flushes the block
- conflict_cnt  out  CNT_W  saturating count of cycles with more than 2 pending slots
- pending_any  out  1  OR of all pending flags

## Operation
State held
- per requester: pend_v[i] and pend_prd[i]
- rr_ptr, an index in 0..NUM_REQ-1
- conflict_cnt

Handshake
- req_ready[i] = ~ovwr & (~pend_v[i] | grant[i]), where ovwr = (rob_state == `ROB_STATE_OVERWRITE_RAT).
- Accept when req_valid[i] & req_ready[i]. Then pend_v[i] <= 1 and pend_prd[i] <= req_prd[i].
- If slot i is granted in the same cycle and no new request arrives, pend_v[i] <= 0.
- Grant-and-accept in the same cycle gives a sustained rate of 1 prd/cycle per requester when that requester is not contending.

Arbitration (combinational from registered state)
- Scan pend_v starting at rr_ptr, wrapping modulo NUM_REQ.
- The first set slot is win0: free0_en=1, free0_rd=pend_prd[win0].
- The next set slot after win0 is win1: free1_en=1, free1_rd=pend_prd[win1].
- Fewer than 2 pending slots leaves the unused port(s) at en=0, rd=0.
- rr_ptr update:
  - 2 grants: rr_ptr <= win1+1 (mod NUM_REQ)
  - 1 grant: rr_ptr <= win0+1 (mod NUM_REQ)
  - 0 grants: rr_ptr unchanged
- Starvation bound: any pending slot is granted within ceil(NUM_REQ/2) cycles.
- Duplicate prds in two slots are both issued; freeing twice is harmless.
- Outputs never depend combinationally on req_valid or req_prd.

Overwrite flush
- While ovwr=1:
  - all pend_v <= 0
  - free0_en = free1_en = 0
  - req_ready = 0
  - rr_ptr <= 0
- Requesters hold their valid; it is accepted on the first cycle after ovwr drops.

Conflict counter
- When popcount(pend_v) > 2 and ovwr=0, conflict_cnt increments by 1.
- It saturates at all-ones.

## Timing
- Reset values:
  - pend_v=0, pend_prd=0, rr_ptr=0, conflict_cnt=0
  - free0_en=0, free0_rd=0, free1_en=0, free1_rd=0
  - pending_any=0
  - req_ready=all-ones, unless ovwr=1
- Latency: a prd accepted at edge N appears on a free port during cycle N+1 at the earliest. It is written into the busy table at edge N+2.
- The busy table's dispatch bypass uses the free ports directly, so a dispatching consumer sees the prd ready during cycle N+1.
- Reset asserted mid-operation discards all pending prds immediately (asynchronous). There is no output glitch beyond en going to 0.
- Accepted prds are never lost except through ovwr or reset.
- rr_ptr wrap: win0=NUM_REQ-1 with win1=0 gives rr_ptr=1.

## Test plan
- Reset, then requester 2 valid with prd=0x15 for one cycle -> next cycle free0_en=1, free0_rd=0x15, free1_en=0; following cycle all en=0, rr_ptr=3.
- All 4 requesters valid in the same cycle with prds 0x01/0x02/0x03/0x04, rr_ptr=0 -> cycle 1 ports carry 0x01 and 0x02; cycle 2 carry 0x03 and 0x04; req_ready[2] and req_ready[3] are 0 during cycle 1; conflict_cnt=1.
- Requester 0 valid every cycle with prd=cycle index, others idle -> free0 carries each prd exactly once, one cycle later; req_ready[0] stays 1 throughout.
- Slots 1 and 3 pending with rr_ptr=2 -> free0_rd=slot 3, free1_rd=slot 1; rr_ptr becomes 2.
- 3 slots pending, then rob_state=OVERWRITE for 1 cycle -> free en=0 and req_ready=0 that cycle; pend_v=0 afterwards; a held req_valid is accepted the next cycle and its prd is issued one cycle later.
- Force conflict_cnt to all-ones (CNT_W=4) with 4 pending slots -> the count stays at 0xF.

Source files
------------

// File: rtl/bt_free_arbiter.sv
// bt_free_arbiter: shares the busy table's two free ports among NUM_REQ writeback requesters.
// Each requester hands one prd per cycle into a one-entry pending slot (valid/ready). A
// round-robin scan drains up to two slots per cycle onto free port 0 and free port 1. While the
// ROB is in the overwrite-RAT state all pending work is dropped and the block stays idle.
//
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   req_valid/req_prd         per-requester handoff, prd i packed at [i*PREG_W +: PREG_W]
//   req_ready                 per-requester accept
//   free0_en/free0_rd         busy-table free port 0
//   free1_en/free1_rd         busy-table free port 1
//   rob_state                 ROB state; overwrite-RAT flushes the block
//   conflict_cnt              saturating count of cycles with more than two slots pending
//   pending_any               OR of all pending flags

`ifndef ROB_STATE_OVERWRITE_RAT
`define ROB_STATE_OVERWRITE_RAT 2'd3
`endif

module bt_free_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PREG_W  = 6,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*PREG_W-1:0] req_prd,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      free0_en,
  output logic [PREG_W-1:0]         free0_rd,
  output logic                      free1_en,
  output logic [PREG_W-1:0]         free1_rd,
  input  logic [1:0]                rob_state,
  output logic [CNT_W-1:0]          conflict_cnt,
  output logic                      pending_any
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] pend_v_q, pend_v_d;
  logic [PREG_W-1:0]  pend_prd_q [NUM_REQ];
  logic [PREG_W-1:0]  pend_prd_d [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;

  logic               ovwr;
  logic               found0, found1;
  logic [PTR_W-1:0]   win0, win1;
  logic [NUM_REQ-1:0] grant;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign ovwr = (rob_state == `ROB_STATE_OVERWRITE_RAT);

  // Round-robin scan from rr_ptr: first pending slot is win0, the next one win1.
  always_comb begin : p_arb
    int unsigned    idx;
    logic [PTR_W-1:0] idx_w;
    found0 = 1'b0;
    found1 = 1'b0;
    win0   = '0;
    win1   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PTR_W'(idx);
      if (pend_v_q[idx_w]) begin
        if (!found0) begin
          found0 = 1'b1;
          win0   = idx_w;
        end else if (!found1) begin
          found1 = 1'b1;
          win1   = idx_w;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant[i] = ~ovwr & ((found0 & (win0 == PTR_W'(i))) | (found1 & (win1 == PTR_W'(i))));
    end
  end

  // Outputs depend only on registered state and rob_state.
  always_comb begin
    free0_en    = found0 & ~ovwr;
    free1_en    = found1 & ~ovwr;
    free0_rd    = free0_en ? pend_prd_q[win0] : '0;
    free1_rd    = free1_en ? pend_prd_q[win1] : '0;
    req_ready   = ~{NUM_REQ{ovwr}} & (~pend_v_q | grant);
    pending_any = |pend_v_q;
  end

  always_comb begin
    pend_v_d   = pend_v_q;
    pend_prd_d = pend_prd_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        pend_v_d[i]   = 1'b1;
        pend_prd_d[i] = req_prd[i*PREG_W +: PREG_W];
      end else if (grant[i]) begin
        pend_v_d[i] = 1'b0;
      end
    end
    if (ovwr) pend_v_d = '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ovwr) begin
      rr_ptr_d = '0;
    end else if (found1) begin
      rr_ptr_d = ptr_inc(win1);
    end else if (found0) begin
      rr_ptr_d = ptr_inc(win0);
    end
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (!ovwr && ($countones(pend_v_q) > 2) && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  assign conflict_cnt = conflict_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_v_q       <= '0;
      rr_ptr_q       <= '0;
      conflict_cnt_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) pend_prd_q[i] <= '0;
    end else begin
      pend_v_q       <= pend_v_d;
      rr_ptr_q       <= rr_ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) pend_prd_q[i] <= pend_prd_d[i];
    end
  end

endmodule
